zacore_fetch_buffered: RTL and testbench

Parametrised successor to the single-register fetch stage. It generates the PC, issues word fetches to instruction memory, and queues returned {pc, inst} pairs in a FETCH_DEPTH-entry FIFO. The FIFO feeds decode over a valid/ready handshake. Execute can redirect the PC (taken branch or jump), and an invalidate input flushes the queue. Sits between IMEM and zacore decode.

---
 rtl/zacore_fetch_buffered.sv | 113 +++++++++++
 tb/tb_zacore_fetch_buffered.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/zacore_fetch_buffered.sv
// zacore_fetch_buffered: PC generator with a FETCH_DEPTH-entry fetch queue.
// Define ZACORE_FETCH_BYPASS_EN for zero-latency fetch when the queue is empty.
module zacore_fetch_buffered #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0,
   parameter int                    FETCH_DEPTH = 4
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   output logic                            o_fetch_req,
   input  logic                            i_fetch_ack,
   output logic [ADDR_WIDTH-3:0]           o_fetch_addr,
   input  logic [31:0]                     i_inst_read,
   output logic                            o_valid,
   input  logic                            i_ready,
   output logic [ADDR_WIDTH-1:0]           o_pc,
   output logic [31:0]                     o_inst,
   input  logic                            i_redirect_valid,
   input  logic [ADDR_WIDTH-1:0]           i_redirect_pc,
   input  logic                            i_invalidate,
   output logic [$clog2(FETCH_DEPTH):0]    o_count
);

   localparam int PW = $clog2(FETCH_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [ADDR_WIDTH-1:0] RST_PC =
      {RESET_ADDR[ADDR_WIDTH-1:2], 2'b00};
   localparam logic [CW-1:0] FULL_CNT = CW'(FETCH_DEPTH);

   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [PW-1:0]         wptr_q, wptr_d;
   logic [PW-1:0]         rptr_q, rptr_d;
   logic [CW-1:0]         cnt_q, cnt_d;

   logic [ADDR_WIDTH-1:0] pc_mem_q   [FETCH_DEPTH];
   logic [31:0]           inst_mem_q [FETCH_DEPTH];

   logic full, nempty, fire, push, pop;

   assign full         = (cnt_q == FULL_CNT);
   assign nempty       = (cnt_q != '0);
   assign o_fetch_req  = ~full & ~i_redirect_valid & ~i_invalidate;
   assign fire         = o_fetch_req & i_fetch_ack;
   assign pop          = nempty & i_ready;
   assign o_fetch_addr = pc_q[ADDR_WIDTH-1:2];
   assign o_count      = cnt_q;

`ifdef ZACORE_FETCH_BYPASS_EN
   logic byp;
   // fire already excludes redirect/invalidate, so the bypass does too
   assign byp     = fire & i_ready & ~nempty;
   assign push    = fire & ~byp;
   assign o_valid = nempty | byp;
   assign o_pc    = byp ? pc_q : pc_mem_q[rptr_q];
   assign o_inst  = byp ? i_inst_read : inst_mem_q[rptr_q];
`else
   assign push    = fire;
   assign o_valid = nempty;
   assign o_pc    = pc_mem_q[rptr_q];
   assign o_inst  = inst_mem_q[rptr_q];
`endif

   // next-state: redirect > invalidate > push/pop
   always_comb begin
      pc_d   = pc_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (i_redirect_valid) begin
         pc_d   = {i_redirect_pc[ADDR_WIDTH-1:2], 2'b00};
         wptr_d = '0;
         rptr_d = '0;
         cnt_d  = '0;
      end else if (i_invalidate) begin
         wptr_d = '0;
         rptr_d = '0;
         cnt_d  = '0;
      end else begin
         if (fire) pc_d = pc_q + ADDR_WIDTH'(4);
         if (push) wptr_d = wptr_q + PW'(1);
         if (pop)  rptr_d = rptr_q + PW'(1);
         unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // control state with synchronous reset
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         pc_q   <= RST_PC;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         pc_q   <= pc_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // queue payload; contents are only meaningful below cnt_q
   always_ff @(posedge i_clk) begin
      if (push) begin
         pc_mem_q[wptr_q]   <= pc_q;
         inst_mem_q[wptr_q] <= i_inst_read;
      end
   end

endmodule

// File: tb/tb_zacore_fetch_buffered.sv
// tb_zacore_fetch_buffered: directed + random stimulus, scoreboard of
// expected {pc, inst} pairs, second instance for PC wraparound.
module tb_zacore_fetch_buffered;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, req, ack, valid, ready, rv, inv;
   logic [29:0] addr;
   logic [31:0] inst, pc, oinst, rpc;
   logic [2:0]  cnt;

   logic        rst2, req2, v2;
   logic [29:0] addr2;
   logic [31:0] inst2, pc2, oinst2;
   logic [2:0]  cnt2;

   zacore_fetch_buffered #(
      .ADDR_WIDTH(32), .RESET_ADDR(32'h0), .FETCH_DEPTH(4)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .o_fetch_req(req), .i_fetch_ack(ack),
      .o_fetch_addr(addr), .i_inst_read(inst),
      .o_valid(valid), .i_ready(ready),
      .o_pc(pc), .o_inst(oinst),
      .i_redirect_valid(rv), .i_redirect_pc(rpc),
      .i_invalidate(inv), .o_count(cnt)
   );

   assign inst2 = {addr2, 2'b00} ^ 32'hA5A5A5A5;

   zacore_fetch_buffered #(
      .ADDR_WIDTH(32), .RESET_ADDR(32'hFFFFFFF8), .FETCH_DEPTH(4)
   ) dut2 (
      .i_clk(clk), .i_rst_n(rst2),
      .o_fetch_req(req2), .i_fetch_ack(1'b1),
      .o_fetch_addr(addr2), .i_inst_read(inst2),
      .o_valid(v2), .i_ready(1'b1),
      .o_pc(pc2), .o_inst(oinst2),
      .i_redirect_valid(1'b0), .i_redirect_pc(32'h0),
      .i_invalidate(1'b0), .o_count(cnt2)
   );

   int          checks = 0;
   int          errors = 0;
   logic [63:0] sb[$];
   logic [31:0] mpc;
   logic [31:0] save_pc;
   bit          chk_en;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      logic        mreq;
      logic [63:0] e;
      inst = mpc ^ 32'hA5A5A5A5;
      #1;
      mreq = (sb.size() < 4) && !rv && !inv;
      if (chk_en) begin
         chk("count", 32'(cnt), 32'(sb.size()));
         chk("valid", 32'(valid), 32'(sb.size() != 0));
         chk("req", 32'(req), 32'(mreq));
         chk("addr", 32'(addr), mpc >> 2);
         if (sb.size() != 0 && ready && !rv && !inv) begin
            e = sb.pop_front();
            chk("pc", pc, e[63:32]);
            chk("inst", oinst, e[31:0]);
         end
      end
      @(posedge clk);
      if (!rst_n) begin
         mpc = 32'h0;
         sb.delete();
         chk_en = 1'b1;
      end else if (rv) begin
         mpc = rpc & ~32'h3;
         sb.delete();
      end else if (inv) begin
         sb.delete();
      end else if (mreq && ack) begin
         sb.push_back({mpc, mpc ^ 32'hA5A5A5A5});
         mpc = mpc + 32'd4;
      end
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; ack = 1'b0; ready = 1'b0;
      rv = 1'b0; inv = 1'b0; rpc = '0;
      rst2 = 1'b0; chk_en = 1'b0; mpc = '0;
      inst = '0;
      @(negedge clk);
      cyc();
      rst_n = 1'b1;
      cyc();

      ack = 1'b1; ready = 1'b1;
      cyc();
      chk("lat_valid", 32'(valid), 32'd1);
      chk("lat_pc", pc, 32'h0);
      repeat (7) cyc();

      rst_n = 1'b0; cyc(); rst_n = 1'b1;
      ready = 1'b0; ack = 1'b1;
      repeat (6) cyc();
      chk("full_cnt", 32'(cnt), 32'd4);
      chk("full_addr", 32'(addr), 32'h4);
      ack = 1'b0; ready = 1'b1;
      repeat (5) cyc();

      ready = 1'b0; ack = 1'b1;
      repeat (3) cyc();
      rv = 1'b1; rpc = 32'h103; ready = 1'b1;
      cyc();
      rv = 1'b0;
      chk("rd_cnt", 32'(cnt), 32'd0);
      chk("rd_valid", 32'(valid), 32'd0);
      chk("rd_addr", 32'(addr), 32'h40);
      repeat (4) cyc();

      ready = 1'b0;
      cyc();
      save_pc = mpc;
      inv = 1'b1;
      cyc();
      inv = 1'b0;
      chk("inv_cnt", 32'(cnt), 32'd0);
      chk("inv_addr", 32'(addr), save_pc >> 2);
      rv = 1'b1; inv = 1'b1; rpc = 32'h200;
      cyc();
      rv = 1'b0; inv = 1'b0;
      chk("rdinv_addr", 32'(addr), 32'h80);

      ready = 1'b0; ack = 1'b1;
      repeat (2) cyc();
      ready = 1'b1;
      repeat (4) cyc();
      chk("pp_cnt", 32'(cnt), 32'd2);

      ready = 1'b0;
      cyc();
      chk("pre_rst_cnt", 32'(cnt), 32'd3);
      rst_n = 1'b0; cyc(); rst_n = 1'b1;
      chk("rst_cnt", 32'(cnt), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_addr", 32'(addr), 32'h0);

      for (int i = 0; i < 120; i++) begin
         ack   = 1'($urandom_range(0, 1));
         ready = 1'($urandom_range(0, 1));
         rv    = ($urandom_range(0, 15) == 0);
         inv   = ($urandom_range(0, 15) == 0);
         rpc   = $urandom;
         cyc();
      end
      rv = 1'b0; inv = 1'b0; ack = 1'b0; ready = 1'b0;

      cyc();
      rst2 = 1'b1;
      chk("w_valid0", 32'(v2), 32'd0);
      chk("w_addr0", 32'(addr2), 32'h3FFFFFFE);
      cyc();
      chk("w_valid1", 32'(v2), 32'd1);
      chk("w_pc1", pc2, 32'hFFFFFFF8);
      chk("w_inst1", oinst2, 32'hFFFFFFF8 ^ 32'hA5A5A5A5);
      cyc();
      chk("w_pc2", pc2, 32'hFFFFFFFC);
      cyc();
      chk("w_pc3", pc2, 32'h00000000);
      chk("w_inst3", oinst2, 32'hA5A5A5A5);
      chk("w_cnt", 32'(cnt2), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
